// File: rtl/floo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : floo_pkg
// Description : Shared types for the credit-based virtual-channel scheduler:
//               scheduler state encoding, default flit layout and an index
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package floo_pkg;

    // Scheduler state: free arbitration or locked onto one VC mid-packet
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } vc_sched_state_e;

    // Default flit layout; any flit type carrying hdr.last may be substituted
    typedef struct packed {
        logic last;
    } floo_hdr_t;

    typedef struct packed {
        floo_hdr_t   hdr;
        logic [31:0] payload;
    } floo_flit_t;

    // Width needed to index num items, never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 32'd1) ? unsigned'($clog2(num)) : 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/floo_vc_credit_counter.sv
`default_nettype none
// ============================================================================
// Module      : floo_vc_credit_counter
// Description : Per-VC credit counter. Starts full, decrements on a sent
//               flit, increments on a returned credit, saturates at the
//               downstream FIFO depth and flags overflow attempts.
// Revision    : 1.0 - initial release
// ============================================================================
module floo_vc_credit_counter #(
    parameter int unsigned CreditDepth = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               inc_i,
    input  logic                               dec_i,
    output logic [$clog2(CreditDepth+1)-1:0]   count_o,
    output logic                               nonzero_o
);

    localparam int unsigned CNT_W = $clog2(CreditDepth + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CreditDepth);

    logic [CNT_W-1:0] r_count;

    // Credit bookkeeping; a simultaneous send and return cancel out
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= MAX_CNT;
        end else if (inc_i && !dec_i) begin
            if (r_count != MAX_CNT) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count_o   = r_count;
    assign nonzero_o = (r_count != '0);

    // A credit returned while already full means upstream/downstream disagree
    CreditOverflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(inc_i && !dec_i && (r_count == MAX_CNT)));

endmodule
`default_nettype wire

// File: rtl/floo_credit_vc_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : floo_credit_vc_scheduler
// Description : Zero-latency round-robin scheduler multiplexing several
//               credit-controlled virtual channels onto one physical link.
//               Multi-flit packets lock the link to their VC until the flit
//               carrying hdr.last has been sent.
//               Optional feature macro FLOO_VC_SCHED_STATS_EN adds the
//               per-VC credit-stall counters on stall_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module floo_credit_vc_scheduler
    import floo_pkg::*;
#(
    parameter int unsigned NumVirtChannels = 2,
    parameter int unsigned CreditDepth     = 4,
    parameter type         flit_t          = floo_flit_t
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumVirtChannels-1:0]             valid_i,
    output logic [NumVirtChannels-1:0]             ready_o,
    input  flit_t [NumVirtChannels-1:0]            data_i,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output flit_t                                  data_o,
    output logic [idx_width(NumVirtChannels)-1:0]  vc_id_o,
    input  logic [NumVirtChannels-1:0]             credit_i
`ifdef FLOO_VC_SCHED_STATS_EN
    ,
    output logic [NumVirtChannels-1:0][15:0]       stall_cnt_o
`endif
);

    localparam int unsigned IDX_W = idx_width(NumVirtChannels);
    localparam int unsigned CNT_W = $clog2(CreditDepth + 1);

    vc_sched_state_e              r_state;
    logic [IDX_W-1:0]             r_lock_vc;
    logic [IDX_W-1:0]             r_rr_ptr;

    logic [CNT_W-1:0]             w_credit [NumVirtChannels];
    logic [NumVirtChannels-1:0]   w_nonzero;
    logic [NumVirtChannels-1:0]   w_eligible;
    logic [NumVirtChannels-1:0]   w_grant;
    logic [NumVirtChannels-1:0]   w_dec;
    logic [IDX_W-1:0]             w_grant_idx;
    logic [IDX_W-1:0]             w_cand;
    logic [IDX_W-1:0]             w_next_ptr;
    logic                         w_found;
    logic                         w_transfer;

    // One credit counter per VC
    for (genvar g = 0; g < NumVirtChannels; g++) begin : g_credit
        assign w_dec[g] = w_transfer & w_grant[g];

        floo_vc_credit_counter #(
            .CreditDepth (CreditDepth)
        ) u_credit (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .inc_i     (credit_i[g]),
            .dec_i     (w_dec[g]),
            .count_o   (w_credit[g]),
            .nonzero_o (w_nonzero[g])
        );

        // Arbitration must never pick a VC that has no downstream space
        DecWithoutCredit: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(w_dec[g] && (w_credit[g] == '0)));
    end

    assign w_eligible = valid_i & w_nonzero;

    // Grant selection: locked VC only, else first eligible from the RR pointer
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_cand      = '0;
        w_found     = 1'b0;
        if (NumVirtChannels == 1) begin
            w_grant[0] = w_eligible[0];
        end else if (r_state == LOCKED) begin
            w_grant[r_lock_vc] = w_eligible[r_lock_vc];
            w_grant_idx        = r_lock_vc;
        end else begin
            for (int unsigned off = 0; off < NumVirtChannels; off++) begin
                w_cand = IDX_W'((32'(r_rr_ptr) + off) % NumVirtChannels);
                if (!w_found && w_eligible[w_cand]) begin
                    w_found         = 1'b1;
                    w_grant[w_cand] = 1'b1;
                    w_grant_idx     = w_cand;
                end
            end
        end
    end

    // Link side is purely combinational; everything is held quiet in reset
    assign valid_o    = rst_ni & (|w_grant);
    assign ready_o    = (rst_ni & ready_i) ? w_grant : '0;
    assign data_o     = data_i[w_grant_idx];
    assign vc_id_o    = w_grant_idx;
    assign w_transfer = valid_o & ready_i;

    assign w_next_ptr = (w_grant_idx == IDX_W'(NumVirtChannels - 1)) ?
                        '0 : (w_grant_idx + IDX_W'(1));

    // Packet lock FSM; the RR pointer only advances at packet boundaries
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_lock_vc <= '0;
            r_rr_ptr  <= '0;
        end else if (w_transfer) begin
            if (data_o.hdr.last) begin
                r_state  <= IDLE;
                r_rr_ptr <= w_next_ptr;
            end else begin
                r_state   <= LOCKED;
                r_lock_vc <= w_grant_idx;
            end
        end
    end

`ifdef FLOO_VC_SCHED_STATS_EN
    // Per-VC count of cycles a VC wanted to send but had no credit
    for (genvar g = 0; g < NumVirtChannels; g++) begin : g_stats
        logic [15:0] r_stall;

        // Saturating stall counter
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_stall <= '0;
            end else if (valid_i[g] && !w_nonzero[g] && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end

        assign stall_cnt_o[g] = r_stall;
    end
`endif

endmodule
`default_nettype wire
